adder_sequencer: RTL and testbench

ADDER_SEQUENCER -- requirements
Module: adder_sequencer

---
 rtl/adder_sequencer.sv | 107 ++++++++++
 tb/tb_adder_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adder_sequencer.sv
// rtl/adder_sequencer.sv - nibble-serial adder/subtractor reusing one 4-bit slice
module adder_sequencer #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   opa, opb, work, work_nx;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           last;
    logic [3:0]     nib_a, nib_b;
    logic [4:0]     slice_sum;
    logic           msb_cin;

    assign last  = (cnt == CW'(NIBBLES - 1));
    assign busy  = (state == RUN);

    // The single shared slice: current nibble of each operand plus the carry chain bit
    assign nib_a     = opa[{cnt, 2'b00} +: 4];
    assign nib_b     = opb[{cnt, 2'b00} +: 4];
    assign slice_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
    // Carry into the top bit of the nibble, recovered from the sum bit
    assign msb_cin   = nib_a[3] ^ nib_b[3] ^ slice_sum[3];

    // Working result with the current nibble spliced in
    always_comb begin
        work_nx = work;
        work_nx[{cnt, 2'b00} +: 4] = slice_sum[3:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: accept start only when idle, leave RUN after the top nibble
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, nibble stepping and publication of the finished result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            work   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    opa   <= a;
                    opb   <= b ^ {W{op_sub}};
                    carry <= op_sub;
                    cnt   <= '0;
                    work  <= '0;
                end
            end else begin
                work  <= work_nx;
                carry <= slice_sum[4];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    result <= work_nx;
                    cout   <= slice_sum[4];
                    ovf    <= msb_cin ^ slice_sum[4];
                    done   <= 1'b1;
                    cnt    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_sequencer.sv
// tb/tb_adder_sequencer.sv - randomized self-checking bench for adder_sequencer
module tb_adder_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0, op4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [15:0] result4;

    logic        start2 = 1'b0, op2 = 1'b0;
    logic [7:0]  a2 = '0, b2 = '0;
    logic        busy2, done2, cout2, ovf2;
    logic [7:0]  result2;

    int checks = 0;
    int errors = 0;

    adder_sequencer #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op_sub(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
    );

    adder_sequencer #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op_sub(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(result2), .cout(cout2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on W = 4n bits
    function automatic void model(input int n, input bit op, input logic [31:0] av,
                                  input logic [31:0] bv, output logic [31:0] r,
                                  output bit c, output bit v);
        int w = 4 * n;
        longint mask = (64'd1 << w) - 1;
        longint x = longint'(av) & mask;
        longint y = longint'(bv) & mask;
        longint s;
        bit sa, sb, sr;
        s  = op ? (x + ((~y) & mask) + 1) : (x + y);
        r  = 32'(s & mask);
        c  = ((s >> w) & 1) != 0;
        sa = ((x >> (w - 1)) & 1) != 0;
        sb = ((y >> (w - 1)) & 1) != 0;
        sr = ((s >> (w - 1)) & 1) != 0;
        v  = op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done2 : done4;
    endfunction

    // One isolated operation on either instance, with operand noise after acceptance
    task automatic run_op(input bit sel, input bit op, input logic [31:0] av,
                          input logic [31:0] bv, input string tag);
        int n = sel ? 2 : 4;
        logic [31:0] er;
        bit ec, ev;
        int k;
        model(n, op, av, bv, er, ec, ev);
        @(negedge clk);
        if (sel) begin start2 = 1; op2 = op; a2 = av[7:0]; b2 = bv[7:0]; end
        else     begin start4 = 1; op4 = op; a4 = av[15:0]; b4 = bv[15:0]; end
        @(posedge clk); #1;
        if (sel) begin start2 = 0; op2 = 1'($urandom); a2 = 8'($urandom); b2 = 8'($urandom); end
        else     begin start4 = 0; op4 = 1'($urandom); a4 = 16'($urandom); b4 = 16'($urandom); end
        check({tag, "_busy"}, sel ? busy2 : busy4, 1);
        k = 0;
        while (!get_done(sel) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, k, n);
        check({tag, "_res"}, sel ? {24'b0, result2} : {16'b0, result4}, er);
        check({tag, "_cout"}, sel ? cout2 : cout4, ec);
        check({tag, "_ovf"}, sel ? ovf2 : ovf4, ev);
        check({tag, "_idle"}, sel ? busy2 : busy4, 0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, get_done(sel), 0);
        check({tag, "_hold"}, sel ? {24'b0, result2} : {16'b0, result4}, er);
    endtask

    initial begin
        logic [15:0] qa[6], qb[6];
        bit qo[6];
        logic [31:0] er;
        bit ec, ev;
        int idx, cyc, last, k, pulses;

        #12;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_result", result4, 0);
        check("rst_flags", {cout4, ovf4}, 0);
        @(negedge clk);
        rst_n = 1;

        run_op(0, 0, 32'h1234, 32'h4321, "add_5555");
        run_op(0, 0, 32'hFFFF, 32'h0001, "add_wrap");
        run_op(0, 0, 32'h7FFF, 32'h0001, "add_ovf");
        run_op(0, 1, 32'h0005, 32'h0007, "sub_neg");
        run_op(0, 1, 32'h8000, 32'h0001, "sub_ovf");
        for (int i = 0; i < 30; i++)
            run_op(0, 1'($urandom), 32'($urandom), 32'($urandom), "rnd4");

        // Back-to-back with start held high; noise on operands while busy
        for (int i = 0; i < 6; i++) begin
            qa[i] = 16'($urandom); qb[i] = 16'($urandom); qo[i] = 1'($urandom);
        end
        @(negedge clk);
        start4 = 1; a4 = qa[0]; b4 = qb[0]; op4 = qo[0];
        idx = 0; cyc = 0; last = -1;
        while (idx < 6 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (done4) begin
                model(4, qo[idx], {16'b0, qa[idx]}, {16'b0, qb[idx]}, er, ec, ev);
                check("b2b_res", {16'b0, result4}, er);
                check("b2b_flags", {cout4, ovf4}, {ec, ev});
                if (last >= 0) check("b2b_gap", cyc - last, 5);
                last = cyc;
                idx++;
                if (idx < 6) begin a4 = qa[idx]; b4 = qb[idx]; op4 = qo[idx]; end
                else start4 = 0;
            end else begin
                a4 = 16'($urandom); b4 = 16'($urandom); op4 = 1'($urandom);
            end
        end
        check("b2b_count", idx, 6);
        start4 = 0;

        // Reset two cycles into an add
        run_op(0, 0, 32'h7FFF, 32'h0001, "pre_rst");
        @(negedge clk);
        start4 = 1; a4 = 16'h1111; b4 = 16'h2222; op4 = 0;
        @(posedge clk); #1;
        start4 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("abort_busy", busy4, 0);
        check("abort_result", result4, 0);
        check("abort_flags", {done4, cout4, ovf4}, 0);
        pulses = 0;
        repeat (3) begin @(posedge clk); #1; if (done4) pulses++; end
        @(negedge clk);
        rst_n = 1;
        start4 = 1; a4 = 16'h0001; b4 = 16'h0001; op4 = 0;
        @(posedge clk); #1;
        start4 = 0;
        check("accept_after_rst", busy4, 1);
        k = 0;
        while (!done4 && k < 20) begin @(posedge clk); #1; k++; end
        check("post_rst_lat", k, 4);
        check("post_rst_res", result4, 16'h0002);
        check("abort_no_done", pulses, 0);

        // Two-nibble instance
        run_op(1, 0, 32'hFF, 32'h01, "n2_wrap");
        for (int i = 0; i < 10; i++)
            run_op(1, 1'($urandom), 32'($urandom), 32'($urandom), "rnd2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
